serial_subtractor: RTL and testbench

//  Bit-serial ripple subtractor: diff = a - b - b_in, one bit per clock, LSB first.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package sub_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } sub_state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out.
// Mirror image of the full-adder cell used in the adder datapath.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow generation/propagation.
   always_comb begin
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor, LSB first, one bit per clock.
// Operands are captured on the accepted start, so the source may change
// them afterwards. diff/b_out are updated only when a result completes.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   sub_state_e state_reg, state_next;

   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] a_sr_reg, a_sr_next;
   logic [WIDTH-1:0] b_sr_reg, b_sr_next;
   logic [WIDTH-1:0] d_sr_reg, d_sr_next;
   logic             br_reg, br_next;
   logic [WIDTH-1:0] diff_reg, diff_next;
   logic             b_out_reg, b_out_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   logic             fs_d;
   logic             fs_bout;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [WIDTH-1:0] d_shift;

   // Single bit-slice working on the current LSBs of the operand registers.
   full_subtractor u_fs (
      .x    (a_sr_reg[0]),
      .y    (b_sr_reg[0]),
      .bin  (br_reg),
      .d    (fs_d),
      .bout (fs_bout)
   );

   // Right-shift networks: operands drain toward bit 0, results enter at the MSB.
   assign a_shift[WIDTH-1] = 1'b0;
   assign b_shift[WIDTH-1] = 1'b0;
   assign d_shift[WIDTH-1] = fs_d;
   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign a_shift[gi] = a_sr_reg[gi+1];
         assign b_shift[gi] = b_sr_reg[gi+1];
         assign d_shift[gi] = d_sr_reg[gi+1];
      end
   endgenerate

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         count_reg <= '0;
         a_sr_reg  <= '0;
         b_sr_reg  <= '0;
         d_sr_reg  <= '0;
         br_reg    <= 1'b0;
         diff_reg  <= '0;
         b_out_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         a_sr_reg  <= a_sr_next;
         b_sr_reg  <= b_sr_next;
         d_sr_reg  <= d_sr_next;
         br_reg    <= br_next;
         diff_reg  <= diff_next;
         b_out_reg <= b_out_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   // Next-state, operand load/shift and result capture.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      a_sr_next  = a_sr_reg;
      b_sr_next  = b_sr_reg;
      d_sr_next  = d_sr_reg;
      br_next    = br_reg;
      diff_next  = diff_reg;
      b_out_next = b_out_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next = SHIFT;
               a_sr_next  = a;
               b_sr_next  = b;
               br_next    = b_in;
               count_next = '0;
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            a_sr_next  = a_shift;
            b_sr_next  = b_shift;
            d_sr_next  = d_shift;
            br_next    = fs_bout;
            count_next = count_reg + CW'(1);
            // The final bit is folded straight into the result so that
            // diff/b_out are valid in the same cycle as done.
            if (count_reg == LAST_BIT) begin
               state_next = DONE;
               diff_next  = d_shift;
               b_out_next = fs_bout;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next == SHIFT);
      done_next = (state_next == DONE);
   end

   assign busy  = busy_reg;
   assign done  = done_reg;
   assign diff  = diff_reg;
   assign b_out = b_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): latency, results,
// ignored start during SHIFT, back-to-back operation and mid-op reset.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       b_in;
   logic       busy;
   logic       done;
   logic [3:0] diff;
   logic       b_out;

   int passed = 0;
   int total  = 0;

   logic [3:0] prev_diff;
   logic       prev_bout;

   serial_subtractor #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (b_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Launch one operation, scramble the inputs after capture and check
   // busy for 4 cycles, done in the 5th, then idle.
   task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                         input logic [3:0] ed, input logic eb, input bit inject);
      a = av; b = bv; b_in = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~av; b = ~bv; b_in = ~bi;
      for (int i = 0; i < 4; i++) begin
         check("busy_in_shift", {7'd0, busy}, 8'd1);
         check("done_in_shift", {7'd0, done}, 8'd0);
         check("diff_stable", {4'd0, diff}, {4'd0, prev_diff});
         check("bout_stable", {7'd0, b_out}, {7'd0, prev_bout});
         if (inject && i == 1) begin
            start = 1'b1; a = 4'b1111; b = 4'b0000; b_in = 1'b0;
         end
         @(negedge clk);
         start = 1'b0;
      end
      check("done_pulse", {7'd0, done}, 8'd1);
      check("busy_at_done", {7'd0, busy}, 8'd0);
      check("diff", {4'd0, diff}, {4'd0, ed});
      check("b_out", {7'd0, b_out}, {7'd0, eb});
      $display("op a=%b b=%b b_in=%b -> diff=%b b_out=%b", av, bv, bi, diff, b_out);
      prev_diff = ed; prev_bout = eb;
      @(negedge clk);
      check("done_one_cycle", {7'd0, done}, 8'd0);
      check("idle_after_done", {7'd0, busy}, 8'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
      prev_diff = '0; prev_bout = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_done", {7'd0, done}, 8'd0);
      check("rst_diff", {4'd0, diff}, 8'd0);
      check("rst_bout", {7'd0, b_out}, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);
      run_op(4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1, 1'b0);
      run_op(4'b0110, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0);
      run_op(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0);
      // start pulsed mid-SHIFT with other operands must be ignored
      run_op(4'b1001, 4'b0011, 1'b0, 4'b0110, 1'b0, 1'b1);

      // Back-to-back: start held high through DONE
      a = 4'b0110; b = 4'b0011; b_in = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 4'b0010; b = 4'b0101; b_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("b2b_busy1", {7'd0, busy}, 8'd1);
         @(negedge clk);
      end
      check("b2b_done1", {7'd0, done}, 8'd1);
      check("b2b_diff1", {4'd0, diff}, 8'h03);
      check("b2b_bout1", {7'd0, b_out}, 8'd0);
      $display("op a=0110 b=0011 b_in=0 -> diff=%b b_out=%b", diff, b_out);
      @(negedge clk);
      start = 1'b0; a = 4'b0000; b = 4'b0000; b_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("b2b_busy2", {7'd0, busy}, 8'd1);
         check("b2b_nodone", {7'd0, done}, 8'd0);
         @(negedge clk);
      end
      check("b2b_done2", {7'd0, done}, 8'd1);
      check("b2b_diff2", {4'd0, diff}, 8'h0C);
      check("b2b_bout2", {7'd0, b_out}, 8'd1);
      $display("op a=0010 b=0101 b_in=1 -> diff=%b b_out=%b", diff, b_out);
      @(negedge clk);
      check("b2b_idle", {7'd0, busy}, 8'd0);

      // Reset asserted in the second SHIFT cycle
      a = 4'b0011; b = 4'b0001; b_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {7'd0, busy}, 8'd0);
      check("mid_rst_done", {7'd0, done}, 8'd0);
      check("mid_rst_diff", {4'd0, diff}, 8'd0);
      check("mid_rst_bout", {7'd0, b_out}, 8'd0);
      $display("reset asserted mid-operation: busy=%b diff=%b", busy, diff);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_done_after_rst", {7'd0, done}, 8'd0);
      end
      prev_diff = '0; prev_bout = 1'b0;
      run_op(4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
